ram_req_adapter: RTL
====================

RAM_REQ_ADAPTER -- requirements
Module: ram_req_adapter

Interface
REQ-001 SHALL have parameter: SIZE, 65536, RAM size in bytes; AW = $clog2(SIZE).
REQ-002 SHALL have port: clk  in  1  clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: i_wr_valid in 1, o_wr_ready out 1, i_wr_addr in AW, i_wr_data in 64, i_wr_strb in 8; these form the write request channel.
REQ-005 SHALL have ports: o_wr_ack out 1, o_wr_err out 1; these form the write completion pulses.
REQ-006 SHALL have ports: i_rd_valid in 1, o_rd_ready out 1, i_rd_addr in AW; these form the read request channel.
REQ-007 SHALL have ports: o_rd_valid out 1, i_rd_ready in 1, o_rd_data out 64, o_rd_err out 1; these form the read response channel.
REQ-008 SHALL have ports: o_ram_we out 8, o_ram_din out 64, o_ram_waddr out AW, o_ram_raddr out AW, i_ram_dout in 64; these drive a 64-bit-wide RAM with byte enables and a registered read (1-cycle latency).

Function
REQ-009 SHALL accept a write on the edge where i_wr_valid && o_wr_ready, driving o_ram_we=i_wr_strb, o_ram_din=i_wr_data and o_ram_waddr=i_wr_addr combinationally in that cycle; otherwise o_ram_we SHALL be 0.
REQ-010 SHALL hold o_wr_ready=1 in every cycle out of reset.
REQ-011 SHALL pulse o_wr_ack for exactly one cycle, in the cycle after each accepted write.
REQ-012 SHALL accept a read on the edge where i_rd_valid && o_rd_ready, driving o_ram_raddr=i_rd_addr in that cycle.
REQ-013 SHALL deassert o_rd_ready (hazard) when an accepted write with nonzero strobe targets the same 64-bit word (addr[AW-1:3]) as i_rd_addr in the same cycle.
REQ-014 SHALL capture i_ram_dout one cycle after read accept into a 2-entry response FIFO, so o_rd_valid rises 2 cycles after accept when the FIFO is empty.
REQ-015 SHALL drive o_rd_ready = !hazard && ((fifo_count + inflight) < 2 || (o_rd_valid && i_rd_ready)); with i_rd_ready held high this sustains 1 read/cycle.
REQ-016 SHALL hold o_rd_data/o_rd_err stable while o_rd_valid && !i_rd_ready, and pop the FIFO on o_rd_valid && i_rd_ready.
REQ-017 SHALL return responses strictly in request order, and SHALL allow a push and a pop in the same cycle without changing occupancy.
REQ-018 SHALL never overflow the FIFO or drop an accepted read.

Reset
REQ-019 SHALL, while rst_n=0, drive o_wr_ready, o_rd_ready, o_rd_valid, o_wr_ack, o_wr_err, o_rd_err and o_ram_we to 0, and o_rd_data to 0.
REQ-020 SHALL, on reset asserted mid-operation, empty the FIFO and discard the in-flight read; no response for a discarded read SHALL appear after reset release.
REQ-021 SHALL allow the first request to be accepted in the first cycle with rst_n=1.

Configuration
REQ-022 SHALL compile address checking in only when macro RAM_REQ_ADAPTER_ADDR_CHECK_EN is defined.
REQ-023 SHALL, with the macro defined, handle a write with addr >= SIZE as follows: accept it, force o_ram_we=0, and pulse o_wr_err together with o_wr_ack.
REQ-024 SHALL, with the macro defined, handle a read with addr >= SIZE as follows: accept it, issue no RAM access, and produce an in-order response with o_rd_data=0 and o_rd_err=1 at normal latency.
REQ-025 SHALL, without the macro, tie o_wr_err and o_rd_err to 0 and pass all addresses unchecked.

Verification
REQ-026 SHALL cover the write-then-read case: write addr 0x10, data 0x0123456789ABCDEF, strb 0xFF; then read 0x10 -> o_wr_ack one cycle after the write, and o_rd_data=0x0123456789ABCDEF 2 cycles after read accept.
REQ-027 SHALL cover a byte-strobe write: write 0x10, strb 0x01, data 0xFF; then read -> o_rd_data=0x0123456789ABCDFF.
REQ-028 SHALL cover streaming with backpressure: 8 back-to-back reads with i_rd_ready=1, giving 8 consecutive o_rd_valid cycles in order; then i_rd_ready=0 -> at most 2 further accepts, o_rd_ready=0, and data held stable.
REQ-029 SHALL cover the same-cycle hazard: write and read to word 0x20 in the same cycle -> o_rd_ready=0 that cycle, the read is accepted the next cycle, and it returns the new data.
REQ-030 SHALL cover reset mid-operation: rst_n=0 one cycle after a read accept -> o_rd_valid stays 0, and the FIFO is empty after release.
REQ-031 SHALL cover SIZE=40000 with the macro defined: read 0x9C40 -> o_rd_err=1 and o_rd_data=0; write 0x9C40 -> o_wr_err pulses and o_ram_we=0.

Source files
------------

// File: rtl/ram_req_adapter_if.sv
// Bundle of request, completion, response and RAM-side signals for
// ram_req_adapter. The slave modport is the adapter's view; the master
// modport is the requester plus the RAM it drives.
interface ram_req_adapter_if #(
  parameter int AW = 16
);
  // write request channel
  logic          i_wr_valid;
  logic          o_wr_ready;
  logic [AW-1:0] i_wr_addr;
  logic [63:0]   i_wr_data;
  logic [7:0]    i_wr_strb;
  // write completion pulses
  logic          o_wr_ack;
  logic          o_wr_err;
  // read request channel
  logic          i_rd_valid;
  logic          o_rd_ready;
  logic [AW-1:0] i_rd_addr;
  // read response channel
  logic          o_rd_valid;
  logic          i_rd_ready;
  logic [63:0]   o_rd_data;
  logic          o_rd_err;
  // RAM port (byte enables, 1-cycle registered read)
  logic [7:0]    o_ram_we;
  logic [63:0]   o_ram_din;
  logic [AW-1:0] o_ram_waddr;
  logic [AW-1:0] o_ram_raddr;
  logic [63:0]   i_ram_dout;

  modport slave (
    input  i_wr_valid, i_wr_addr, i_wr_data, i_wr_strb,
    output o_wr_ready, o_wr_ack, o_wr_err,
    input  i_rd_valid, i_rd_addr, i_rd_ready,
    output o_rd_ready, o_rd_valid, o_rd_data, o_rd_err,
    output o_ram_we, o_ram_din, o_ram_waddr, o_ram_raddr,
    input  i_ram_dout
  );

  modport master (
    output i_wr_valid, i_wr_addr, i_wr_data, i_wr_strb,
    input  o_wr_ready, o_wr_ack, o_wr_err,
    output i_rd_valid, i_rd_addr, i_rd_ready,
    input  o_rd_ready, o_rd_valid, o_rd_data, o_rd_err,
    input  o_ram_we, o_ram_din, o_ram_waddr, o_ram_raddr,
    output i_ram_dout
  );
endinterface

// File: rtl/ram_req_adapter.sv
// ram_req_adapter: valid/ready write and read channels onto a 64-bit RAM
// with byte enables and a registered read. Writes complete with a one-cycle
// ack pulse; read data lands in a 2-entry in-order response FIFO.
// Optional: define RAM_REQ_ADAPTER_ADDR_CHECK_EN to reject addr >= SIZE
// (write is dropped with o_wr_err, read returns zero data with o_rd_err).
module ram_req_adapter #(
  parameter int SIZE = 65536
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_req_adapter_if.slave bus
);
  localparam int AW = $clog2(SIZE);

  logic            wr_fire;
  logic            rd_fire;
  logic            hazard;
  logic            pop;
  logic            push;
  logic            wr_oob;
  logic            rd_oob;
  logic            inflight;   // read accepted last cycle, RAM data valid now
  logic            ack_q;
  logic [1:0]      cnt;
  logic [1:0]      occ;
  logic            wptr;
  logic            rptr;
  logic [1:0][63:0] fifo_d;
  logic [63:0]     cap_d;

`ifdef RAM_REQ_ADAPTER_ADDR_CHECK_EN
  localparam logic [31:0] SIZE_U = 32'(SIZE);

  logic       inflight_err;
  logic [1:0] fifo_e;
  logic       wr_err_q;

  assign wr_oob = {{(32-AW){1'b0}}, bus.i_wr_addr} >= SIZE_U;
  assign rd_oob = {{(32-AW){1'b0}}, bus.i_rd_addr} >= SIZE_U;
  // out-of-range reads never touch the RAM, so their data is forced to zero
  assign cap_d  = inflight_err ? '0 : bus.i_ram_dout;

  // error side-band travels alongside the read pipeline and FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_err <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      inflight_err <= rd_fire && rd_oob;
      wr_err_q     <= wr_fire && wr_oob;
      if (push) fifo_e[wptr] <= inflight_err;
    end
  end

  assign bus.o_wr_err = rst_n && wr_err_q;
  assign bus.o_rd_err = bus.o_rd_valid && fifo_e[rptr];
`else
  assign wr_oob       = 1'b0;
  assign rd_oob       = 1'b0;
  assign cap_d        = bus.i_ram_dout;
  assign bus.o_wr_err = 1'b0;
  assign bus.o_rd_err = 1'b0;
`endif

  // write channel: always ready out of reset, RAM write is purely combinational
  assign bus.o_wr_ready  = rst_n;
  assign wr_fire         = bus.i_wr_valid && bus.o_wr_ready;
  assign bus.o_ram_we    = (wr_fire && !wr_oob) ? bus.i_wr_strb : 8'h00;
  assign bus.o_ram_din   = bus.i_wr_data;
  assign bus.o_ram_waddr = bus.i_wr_addr;
  assign bus.o_wr_ack    = rst_n && ack_q;

  // read-after-write to the same word in one cycle would read stale RAM data
  assign hazard = wr_fire && (bus.i_wr_strb != 8'h00) &&
                  (bus.i_wr_addr[AW-1:3] == bus.i_rd_addr[AW-1:3]);

  // occupancy counts in-flight reads so the FIFO can never overflow
  assign occ            = cnt + {1'b0, inflight};
  assign pop            = bus.o_rd_valid && bus.i_rd_ready;
  assign bus.o_rd_ready = rst_n && !hazard && ((occ < 2'd2) || pop);
  assign rd_fire        = bus.i_rd_valid && bus.o_rd_ready;
  assign bus.o_ram_raddr = rd_oob ? '0 : bus.i_rd_addr;
  assign push           = inflight;

  assign bus.o_rd_valid = rst_n && (cnt != 2'd0);
  assign bus.o_rd_data  = bus.o_rd_valid ? fifo_d[rptr] : 64'h0;

  // read pipeline, response FIFO and write-ack pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      ack_q    <= 1'b0;
      cnt      <= 2'd0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
    end else begin
      inflight <= rd_fire;
      ack_q    <= wr_fire;
      if (push) begin
        fifo_d[wptr] <= cap_d;
        wptr         <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end
endmodule
